// File: rtl/vec_dot_seq_if.sv
// Port bundle between the dot-product sequencer, its operand buffers and the PE.
// master is the sequencer side; slave is the controller/buffer/PE side.
interface vec_dot_seq_if #(
    parameter int ADDR_W = 10
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic signed [15:0]       result;
    logic                     sat;
    logic                     err;
    logic                     mem_rd;
    logic        [ADDR_W-1:0] mem_addr;
    logic signed [15:0]       mem_a_rdata;
    logic signed [15:0]       mem_b_rdata;
    logic                     pe_rst;
    logic                     pe_en;
    logic signed [15:0]       vec_a;
    logic signed [15:0]       vec_b;
    logic signed [15:0]       pe_dot;
    logic                     pe_finish;

    modport master (
        input  start,
        output busy, done, result, sat, err,
        output mem_rd, mem_addr,
        input  mem_a_rdata, mem_b_rdata,
        output pe_rst, pe_en, vec_a, vec_b,
        input  pe_dot, pe_finish
    );

    modport slave (
        output start,
        input  busy, done, result, sat, err,
        input  mem_rd, mem_addr,
        output mem_a_rdata, mem_b_rdata,
        input  pe_rst, pe_en, vec_a, vec_b,
        output pe_dot, pe_finish
    );
endinterface

// File: rtl/vec_dot_seq.sv
// Streams VEC_LEN operand pairs through a Q1.14 multiply PE and accumulates the
// products into one saturated Q1.14 dot product.
module vec_dot_seq #(
    parameter int VEC_LEN = 784,
    parameter int ADDR_W  = 10,
    parameter int ACC_W   = 32
) (
    input  logic          clk,
    input  logic          rst,
    vec_dot_seq_if.master bus
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic        [ADDR_W-1:0] LAST_ADDR = ADDR_W'(VEC_LEN - 1);
    localparam logic signed [ACC_W-1:0]  SAT_MAX   = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0]  SAT_MIN   = -(ACC_W'(32768));

    state_t                    state, state_nxt;
    logic                      accept;
    logic                      last_issue;
    logic                      drained;
    logic        [ADDR_W-1:0]  addr;
    // [0] operands returned by the buffers, [1] operands at the PE, [2] product at pe_dot
    logic        [2:0]         vld_pipe;
    logic signed [ACC_W-1:0]   acc, acc_nxt;
    logic signed [15:0]        result_q, result_nxt;
    logic                      sat_q, sat_nxt;
    logic                      err_q;
    logic                      pe_clr;
    logic signed [15:0]        vec_a_q, vec_b_q;

    assign last_issue = (addr == LAST_ADDR);
    assign drained    = (vld_pipe[1:0] == 2'b00);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                state_nxt = RUN;
                accept    = 1'b1;
            end
            RUN:   if (last_issue) state_nxt = DRAIN;
            DRAIN: if (drained) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // The last product lands on the same edge that enters DONE, so saturate the
    // post-accumulate value rather than the register.
    always_comb begin
        acc_nxt = acc;
        if (vld_pipe[2])
            acc_nxt = acc + {{(ACC_W-16){bus.pe_dot[15]}}, bus.pe_dot};
        result_nxt = acc_nxt[15:0];
        sat_nxt    = 1'b0;
        if (acc_nxt > SAT_MAX) begin
            result_nxt = 16'sh7fff;
            sat_nxt    = 1'b1;
        end else if (acc_nxt < SAT_MIN) begin
            result_nxt = -16'sh8000;
            sat_nxt    = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            addr     <= '0;
            vld_pipe <= '0;
            acc      <= '0;
            result_q <= '0;
            sat_q    <= 1'b0;
            err_q    <= 1'b0;
            pe_clr   <= 1'b1;
            vec_a_q  <= '0;
            vec_b_q  <= '0;
        end else begin
            state    <= state_nxt;
            pe_clr   <= accept;
            vld_pipe <= {vld_pipe[1:0], (state == RUN)};

            if (vld_pipe[0]) begin
                vec_a_q <= bus.mem_a_rdata;
                vec_b_q <= bus.mem_b_rdata;
            end

            if (accept || state == DONE)
                addr <= '0;
            else if (state == RUN && !last_issue)
                addr <= addr + 1'b1;

            acc <= accept ? '0 : acc_nxt;

            if (accept)
                err_q <= 1'b0;
            else if (vld_pipe[2] && !bus.pe_finish)
                err_q <= 1'b1;

            if (state == DRAIN && drained) begin
                result_q <= result_nxt;
                sat_q    <= sat_nxt;
            end
        end
    end

    assign bus.busy     = (state != IDLE);
    assign bus.done     = (state == DONE);
    assign bus.result   = result_q;
    assign bus.sat      = sat_q;
    assign bus.err      = err_q;
    assign bus.mem_rd   = (state == RUN);
    assign bus.mem_addr = addr;
    assign bus.pe_rst   = pe_clr;
    assign bus.pe_en    = vld_pipe[1];
    assign bus.vec_a    = vec_a_q;
    assign bus.vec_b    = vec_b_q;
endmodule

// File: tb/tb_vec_dot_seq.sv
// Directed bench for vec_dot_seq: a VEC_LEN=4 instance for timing/saturation/protocol
// cases and a default VEC_LEN=784 instance checked against a golden sum.
module tb_vec_dot_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic kill = 1'b0;
    int   n_asrt = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    vec_dot_seq_if #(.ADDR_W(10)) b4 ();
    vec_dot_seq_if #(.ADDR_W(10)) b7 ();

    vec_dot_seq #(.VEC_LEN(4), .ADDR_W(10), .ACC_W(32)) dut4 (.clk(clk), .rst(rst), .bus(b4));
    vec_dot_seq #(.VEC_LEN(784), .ADDR_W(10), .ACC_W(32)) dut7 (.clk(clk), .rst(rst), .bus(b7));

    logic signed [15:0] ma4 [0:1023];
    logic signed [15:0] mb4 [0:1023];
    logic signed [15:0] ma7 [0:1023];
    logic signed [15:0] mb7 [0:1023];
    logic signed [15:0] pd4, pd7;
    logic               pf4, pf7;
    int                 pc4, pc7;

    function automatic logic signed [15:0] pe_mul(input logic signed [15:0] a, input logic signed [15:0] b);
        int p;
        p = int'(a) * int'(b);
        return 16'(p >>> 14);
    endfunction

    // Synchronous-read buffers and PE models for both instances
    always @(posedge clk) begin
        if (b4.mem_rd) begin
            b4.mem_a_rdata <= ma4[b4.mem_addr];
            b4.mem_b_rdata <= mb4[b4.mem_addr];
        end
        if (b7.mem_rd) begin
            b7.mem_a_rdata <= ma7[b7.mem_addr];
            b7.mem_b_rdata <= mb7[b7.mem_addr];
        end
        if (b4.pe_rst) begin
            pd4 <= '0; pf4 <= 1'b0; pc4 <= 0;
        end else if (b4.pe_en) begin
            pd4 <= pe_mul(b4.vec_a, b4.vec_b); pf4 <= 1'b1; pc4 <= pc4 + 1;
        end
        if (b7.pe_rst) begin
            pd7 <= '0; pf7 <= 1'b0; pc7 <= 0;
        end else if (b7.pe_en) begin
            pd7 <= pe_mul(b7.vec_a, b7.vec_b); pf7 <= 1'b1; pc7 <= pc7 + 1;
        end
    end

    assign b4.pe_dot    = pd4;
    assign b4.pe_finish = pf4 && !(kill && pc4 == 2);
    assign b7.pe_dot    = pd7;
    assign b7.pe_finish = pf7;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load4(input logic signed [15:0] a0, input logic signed [15:0] a1,
                         input logic signed [15:0] a2, input logic signed [15:0] a3,
                         input logic signed [15:0] b);
        ma4[0] = a0; ma4[1] = a1; ma4[2] = a2; ma4[3] = a3;
        for (int i = 0; i < 4; i++) mb4[i] = b;
    endtask

    // One VEC_LEN=4 run; start in cycle S, done expected exactly in S+8.
    // With pulse set, start is also raised in a RUN cycle and in the DONE cycle.
    task automatic run4(input string tag, input logic signed [15:0] er, input logic es,
                        input logic ee, input bit pulse);
        int n_en;
        n_en = 0;
        b4.start = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            b4.start = 1'b0;
            if (k == 1) begin
                chk({tag, " busy@S+1"}, 32'(b4.busy), 32'(1'b1));
                chk({tag, " pe_rst@S+1"}, 32'(b4.pe_rst), 32'(1'b1));
                chk({tag, " err_clr@S+1"}, 32'(b4.err), 32'(1'b0));
            end
            if (b4.pe_en) n_en++;
            if (k < 8) chk({tag, " done_early"}, 32'(b4.done), 32'(1'b0));
            if (pulse && (k == 2 || k == 8)) b4.start = 1'b1;
        end
        chk({tag, " done@S+8"}, 32'(b4.done), 32'(1'b1));
        chk({tag, " result"}, 32'(b4.result), 32'(er));
        chk({tag, " sat"}, 32'(b4.sat), 32'(es));
        chk({tag, " err"}, 32'(b4.err), 32'(ee));
        chk({tag, " pe_en_cycles"}, 32'(n_en), 32'(4));
        tick();
        b4.start = 1'b0;
        chk({tag, " idle_busy"}, 32'(b4.busy), 32'(1'b0));
        chk({tag, " idle_addr"}, 32'(b4.mem_addr), 32'(0));
        if (pulse) begin
            tick();
            chk({tag, " done_start_ignored"}, 32'(b4.busy), 32'(1'b0));
        end
    endtask

    initial begin
        int gacc;
        int k7;
        logic signed [15:0] gres;
        logic gsat;

        b4.start = 1'b0;
        b7.start = 1'b0;
        for (int i = 0; i < 1024; i++) begin
            ma4[i] = '0; mb4[i] = '0;
            ma7[i] = 16'(i * 41 - 16000);
            mb7[i] = 16'(int'(i % 61) - 30);
        end

        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        chk("rst busy", 32'(b4.busy), 32'(1'b0));
        chk("rst done", 32'(b4.done), 32'(1'b0));
        chk("rst result", 32'(b4.result), 32'(0));
        chk("rst sat_err", {30'd0, b4.sat, b4.err}, 32'(0));
        chk("rst mem", {b4.mem_rd, 21'd0, b4.mem_addr}, 32'(0));
        chk("rst pe_en", 32'(b4.pe_en), 32'(1'b0));
        chk("rst vec", {b4.vec_a, b4.vec_b}, 32'(0));
        chk("rst pe_rst", 32'(b4.pe_rst), 32'(1'b1));
        tick();

        load4(16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192);
        run4("half", 16'sd16384, 1'b0, 1'b0, 1'b0);
        chk("half vec_a_hold", 32'(b4.vec_a), 32'(16'sd8192));

        load4(16'sd32767, 16'sd32767, 16'sd32767, 16'sd32767, 16'sd16384);
        run4("satpos", 16'sd32767, 1'b1, 1'b0, 1'b0);
        load4(-16'sd32768, -16'sd32768, -16'sd32768, -16'sd32768, 16'sd16384);
        run4("satneg", -16'sd32768, 1'b1, 1'b0, 1'b0);

        load4(-16'sd1, -16'sd1, -16'sd1, -16'sd1, 16'sd1);
        run4("neg1", -16'sd4, 1'b0, 1'b0, 1'b0);
        load4(16'sd16384, -16'sd16384, 16'sd8192, -16'sd8192, 16'sd16384);
        run4("mixed", 16'sd0, 1'b0, 1'b0, 1'b0);

        // Abort with reset in cycle S+3
        load4(16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192);
        b4.start = 1'b1;
        tick(); b4.start = 1'b0;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort pe_en", 32'(b4.pe_en), 32'(1'b0));
        chk("abort busy", 32'(b4.busy), 32'(1'b0));
        chk("abort pe_rst", 32'(b4.pe_rst), 32'(1'b1));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("abort no_done", 32'(b4.done), 32'(1'b0));
        end
        chk("abort result", 32'(b4.result), 32'(0));
        run4("after_abort", 16'sd16384, 1'b0, 1'b0, 1'b0);

        load4(16'sd16384, 16'sd16384, -16'sd8192, 16'sd4096, 16'sd16384);
        run4("pulse", 16'sd28672, 1'b0, 1'b0, 1'b1);

        // start held high: done in cycles 8, 17, 26 relative to the first start
        load4(16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192, 16'sd8192);
        b4.start = 1'b1;
        for (int k = 1; k <= 27; k++) begin
            tick();
            if (k == 26) b4.start = 1'b0;
            chk("held done", 32'(b4.done), 32'((k % 9) == 8));
        end
        chk("held idle", 32'(b4.busy), 32'(1'b0));
        tick();

        kill = 1'b1;
        run4("kill2", 16'sd16384, 1'b0, 1'b1, 1'b0);
        kill = 1'b0;
        run4("kill_clear", 16'sd16384, 1'b0, 1'b0, 1'b0);

        // Full-length run against a golden sum
        gacc = 0;
        for (int i = 0; i < 784; i++) gacc += int'(pe_mul(ma7[i], mb7[i]));
        gsat = 1'b0;
        gres = 16'(gacc);
        if (gacc > 32767) begin gres = 16'sh7fff; gsat = 1'b1; end
        else if (gacc < -32768) begin gres = -16'sh8000; gsat = 1'b1; end
        b7.start = 1'b1;
        k7 = 0;
        tick();
        b7.start = 1'b0;
        k7 = 1;
        while (!b7.done && k7 < 1000) begin
            tick();
            k7++;
        end
        chk("len784 done_cycle", 32'(k7), 32'(788));
        chk("len784 result", 32'(b7.result), 32'(gres));
        chk("len784 sat", 32'(b7.sat), 32'(gsat));
        chk("len784 err", 32'(b7.err), 32'(1'b0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_dot_seq.md
Name: vec_dot_seq

Overview:
- Sequencer and accumulator that drives the single-element Q1.14 multiply PE (vec_dot_basic: `en` in; `dot_out` and `finish` out).
- On `start`, streams VEC_LEN element pairs from two synchronous-read vector buffers into the PE, one per cycle.
- Collects each PE product, accumulates it in a wide register, and returns one saturated Q1.14 dot-product result with a `done` pulse.
- Sits between the layer controller and each PE in the 1x784 * 784x64 array.

Parameters:
VEC_LEN, 784, number of element pairs per dot product (1 <= VEC_LEN <= 2**ADDR_W)
ADDR_W, 10, buffer address width
ACC_W, 32, signed accumulator width (>= 16 + clog2(VEC_LEN))

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  begin a dot product; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted through the done cycle
done  out  1  one-cycle pulse; result and sat are valid in this cycle
result  out  16  signed Q1.14 saturated dot product; held until the next done
sat  out  1  result was clipped; held with result
err  out  1  sticky: pe_finish was low in an accumulate cycle; cleared by rst or start
mem_rd  out  1  buffer read strobe
mem_addr  out  ADDR_W  element index, shared by both buffers
mem_a_rdata  in  16  signed operand A, valid the cycle after mem_rd
mem_b_rdata  in  16  signed operand B, valid the cycle after mem_rd
pe_rst  out  1  PE clear; registered, high while rst and for one cycle after start is accepted
pe_en  out  1  PE enable, registered
vec_a  out  16  signed operand to PE, registered
vec_b  out  16  signed operand to PE, registered
pe_dot  in  16  PE product (a*b)>>>14, valid the cycle after pe_en
pe_finish  in  1  PE finish flag (sticky in PE)

Behaviour:
- Reset (sync, rst=1 at clk edge): state=IDLE. All outputs are 0 (result, sat, err, busy, done, mem_rd, mem_addr, pe_en, vec_a, vec_b). pe_rst=1. Accumulator and counters are 0.
- Reset mid-operation aborts the run. No done is produced, and pe_en is low from the next cycle.
- States:
  - IDLE -> RUN when start=1. Accepted at edge S: accumulator cleared, err cleared, pe_rst=1 during cycle S+1.
  - RUN: issues element i during cycle S+1+i (mem_rd=1, mem_addr=i), for i = 0 .. VEC_LEN-1. After the last issue -> DRAIN.
  - DRAIN: mem_rd=0; waits for the 3-stage in-flight count to reach 0, then -> DONE.
  - DONE: done=1 for one cycle, then -> IDLE.
- Pipeline per element i (fixed, no stalls):
  - Address in cycle S+1+i.
  - rdata is registered into vec_a/vec_b with pe_en=1 in cycle S+3+i.
  - PE captures at the end of S+3+i.
  - pe_dot is accumulated at the end of S+4+i.
- Consequences of the fixed pipeline:
  - pe_en is high for exactly VEC_LEN consecutive cycles.
  - vec_a/vec_b hold their last value after pe_en drops.
- done is asserted in cycle S+VEC_LEN+4. busy is high during S+1 .. S+VEC_LEN+4.
- Accumulate: acc <= acc + sign_extend(pe_dot, ACC_W). No wrap is possible given the ACC_W constraint.
- Result at DONE:
  - acc > 32767: result=32767, sat=1.
  - acc < -32768: result=-32768, sat=1.
  - Otherwise result=acc[15:0], sat=0.
  - result/sat update only on the edge entering DONE.
- Protocol check: if pe_finish=0 in any accumulate cycle, err <= 1. The accumulation proceeds anyway.
- start while busy is ignored. start in the DONE cycle is ignored; a new start is taken from IDLE only.
- Back-to-back runs: start held high restarts on the first IDLE cycle. Minimum period is VEC_LEN+5 cycles.
- VEC_LEN=1: RUN lasts one cycle; done in cycle S+5.
- mem_addr wraps nowhere. It holds VEC_LEN-1 after RUN and returns to 0 in IDLE.

Test Plan:
- VEC_LEN=4; all A=8192, B=8192 (0.5*0.5); start in cycle S -> pe_dot=4096 x4, result=16384, sat=0, done exactly in cycle S+8, err=0.
- VEC_LEN=4; A=32767, B=16384 -> pe_dot=32767 each, acc=131068 -> result=32767, sat=1. Then A=-32768, B=16384 -> result=-32768, sat=1.
- VEC_LEN=4; A=-1, B=1 -> pe_dot=-1 (arithmetic shift), result=-4, sat=0. Mixed signs {16384,-16384,8192,-8192} with B=16384 -> result=0.
- rst asserted in cycle S+3 of a run -> next cycle pe_en=0, busy=0, pe_rst=1; no done. A fresh start then completes with the correct result.
- start pulsed during RUN and during DONE -> ignored. start held high continuously -> runs repeat with done every 9 cycles (VEC_LEN=4).
- PE model forces pe_finish=0 on the 2nd product -> err=1 at done, result unaffected. err clears on the next start. VEC_LEN=784 default run matches a golden model.
